// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and
// Gray/binary pointer conversions used by both read and write controllers.
package fifo_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 3;
   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

   typedef logic [PTR_WIDTH-1:0] ptr_t;

   // Helpers take a 32-bit value so any narrower pointer can be zero-extended in.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin = gray;
      for (int i = 1; i < 32; i++) begin
         bin = bin ^ (gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter for a synchronised FIFO pointer;
// each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
   parameter int WIDTH = fifo_pkg::PTR_WIDTH
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o = gray_i;
      for (int i = 1; i < WIDTH; i++) begin
         bin_o = bin_o ^ (gray_i >> i);
      end
   end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, empty/level
// flags against the synchronised write pointer, and a FWFT output register.
module fifo_rd_ctrl #(
   parameter int DATA_WIDTH    = fifo_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH    = fifo_pkg::ADDR_WIDTH,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic                  rempty,
   output logic                  raempty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data
);

   import fifo_pkg::*;

   localparam int PW = ADDR_WIDTH + 1;

   logic [PW-1:0]         rbin_q, rbin_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [PW-1:0]         count_q, count_d;
   logic [PW-1:0]         wbin;
   logic                  rempty_q, rempty_d;
   logic                  raempty_q, raempty_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  fetch;

   fifo_gray2bin #(
      .WIDTH (PW)
   ) u_wptr_g2b (
      .gray_i (rq2_wptr),
      .bin_o  (wbin)
   );

   // Flags are computed from the post-fetch pointer so that a word taken this
   // edge is already excluded; rempty can only be late, never early.
   always_comb begin
      fetch     = !rempty_q && (!valid_q || rd_ready);
      rbin_d    = rbin_q + PW'(fetch);
      rptr_d    = rbin_d ^ (rbin_d >> 1);
      rempty_d  = (rptr_d == rq2_wptr);
      count_d   = wbin - rbin_d;
      raempty_d = (32'(count_d) <= 32'(AEMPTY_THRESH));
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (fetch) begin
         data_d  = rdata_mem;
         valid_d = 1'b1;
      end else if (valid_q && rd_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         valid_q   <= 1'b0;
         data_q    <= '0;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
      end
   end

   assign raddr    = rbin_q[ADDR_WIDTH-1:0];
   assign rptr     = rptr_q;
   assign rempty   = rempty_q;
   assign raempty  = raempty_q;
   assign rd_count = count_q;
   assign rd_valid = valid_q;
   assign rd_data  = data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a word-count model of the FIFO read
// side is stepped alongside the DUT while the bench plays the write side.
module tb_fifo_rd_ctrl;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int PW = 4;

   logic          rclk = 1'b0;
   logic          rrst = 1'b0;
   logic          rd_ready = 1'b0;
   logic [PW-1:0] rq2_wptr = '0;
   logic [DW-1:0] rdata_mem;
   logic [AW-1:0] raddr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] rd_count;
   logic          rempty;
   logic          raempty;
   logic          rd_valid;
   logic [DW-1:0] rd_data;

   logic [DW-1:0] mem [8];

   int total = 0;
   int bad   = 0;

   // Reference model: words written/fetched so far and the output register
   int            wcount;
   int            rcount;
   int            mCount;
   bit            mValid;
   bit            mEmpty;
   bit            mAempty;
   logic [DW-1:0] mData;
   logic [DW-1:0] words[$];
   logic [DW-1:0] received[$];

   always #5 rclk = ~rclk;

   assign rdata_mem = mem[raddr];

   fifo_rd_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .AEMPTY_THRESH (1)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rq2_wptr  (rq2_wptr),
      .rdata_mem (rdata_mem),
      .raddr     (raddr),
      .rptr      (rptr),
      .rempty    (rempty),
      .raempty   (raempty),
      .rd_count  (rd_count),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data)
   );

   function automatic logic [PW-1:0] gray(input int b);
      logic [PW-1:0] x;
      x = PW'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic writeWord(input logic [DW-1:0] d);
      mem[wcount % 8] = d;
      words.push_back(d);
      wcount++;
      rq2_wptr = gray(wcount);
   endtask

   task automatic stepCycle(input bit ready);
      bit fetch;
      rd_ready = ready;
      if (rd_valid === 1'b1 && ready) received.push_back(rd_data);
      fetch = mEmpty == 1'b0 && (!mValid || ready);
      if (fetch) begin
         mData  = words[rcount];
         mValid = 1'b1;
         rcount++;
      end else if (mValid && ready) begin
         mValid = 1'b0;
      end
      mCount  = wcount - rcount;
      mEmpty  = (mCount == 0);
      mAempty = (mCount <= 1);
      @(posedge rclk);
      #1;
   endtask

   task automatic doReset();
      rrst     = 1'b1;
      rd_ready = 1'b0;
      rq2_wptr = '0;
      wcount   = 0;
      rcount   = 0;
      mCount   = 0;
      mValid   = 1'b0;
      mEmpty   = 1'b1;
      mAempty  = 1'b1;
      mData    = '0;
      words.delete();
      received.delete();
      #2;
      rrst = 1'b0;
      stepCycle(1'b0);
   endtask

   task automatic test_reset();
      logic [21:0] obs, exp;
      rrst = 1'b0;
      #1;
      rrst = 1'b1;
      #1;
      obs = {rd_valid, rempty, raempty, rptr, rd_count, raddr, rd_data};
      exp = {1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 3'h0, 8'h00};
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL reset_state: got %h expected %h", obs, exp);
      end
      doReset();
   endtask

   task automatic test_single_word();
      doReset();
      writeWord(8'hA5);
      stepCycle(1'b0);
      total++;
      if ({rempty, rd_count, raempty, rd_valid} !== {1'b0, 4'd1, 1'b1, 1'b0}) begin
         bad++;
         $display("[TB] FAIL single_flags: got %b expected %b",
                  {rempty, rd_count, raempty, rd_valid}, {1'b0, 4'd1, 1'b1, 1'b0});
      end
      stepCycle(1'b0);
      total++;
      if ({rd_valid, rd_data, rempty, rptr} !== {1'b1, 8'hA5, 1'b1, 4'b0001}) begin
         bad++;
         $display("[TB] FAIL single_fetch: got %h expected %h",
                  {rd_valid, rd_data, rempty, rptr}, {1'b1, 8'hA5, 1'b1, 4'b0001});
      end
      for (int c = 0; c < 5; c++) begin
         stepCycle(1'b0);
         total++;
         if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            bad++;
            $display("[TB] FAIL single_hold%0d: got %h expected %h", c, {rd_valid, rd_data}, {1'b1, 8'hA5});
         end
      end
      stepCycle(1'b1);
      total++;
      if (rd_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_consume: got rd_valid=%b expected 0", rd_valid);
      end
   endtask

   task automatic test_streaming();
      doReset();
      for (int i = 0; i < 8; i++) writeWord(8'(8'h10 + i));
      stepCycle(1'b1);
      total++;
      if ({rd_count, rempty, rd_valid} !== {4'd8, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL stream_full: got %b expected %b", {rd_count, rempty, rd_valid}, {4'd8, 1'b0, 1'b0});
      end
      for (int k = 0; k < 8; k++) begin
         stepCycle(1'b1);
         total++;
         if ({rd_valid, rd_data} !== {1'b1, 8'(8'h10 + k)}) begin
            bad++;
            $display("[TB] FAIL stream_word%0d: got %h expected %h", k, {rd_valid, rd_data}, {1'b1, 8'(8'h10 + k)});
         end
      end
      total++;
      if ({rempty, rptr, rd_count} !== {1'b1, 4'b1100, 4'd0}) begin
         bad++;
         $display("[TB] FAIL stream_end: got %b expected %b", {rempty, rptr, rd_count}, {1'b1, 4'b1100, 4'd0});
      end
   endtask

   task automatic test_backpressure();
      logic [21:0] obs, exp;
      doReset();
      for (int i = 0; i < 8; i++) writeWord(8'($urandom));
      for (int c = 0; c < 40; c++) begin
         stepCycle(c % 3 == 0);
         obs = {rd_valid, rd_data, rempty, raempty, rd_count, rptr, raddr};
         exp = {mValid, mData, mEmpty, mAempty, 4'(mCount), gray(rcount), 3'(rcount)};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL bp_cycle%0d: got %h expected %h", c, obs, exp);
         end
      end
      total++;
      if (received.size() != 8) begin
         bad++;
         $display("[TB] FAIL bp_count: got %0d words expected 8", received.size());
      end
      for (int i = 0; i < 8 && i < received.size(); i++) begin
         total++;
         if (received[i] !== words[i]) begin
            bad++;
            $display("[TB] FAIL bp_order%0d: got %h expected %h", i, received[i], words[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [21:0] obs, exp;
      int written;
      doReset();
      written = 0;
      for (int c = 0; c < 300 && received.size() < 20; c++) begin
         if (written < 20 && wcount - rcount <= 5 && $urandom_range(0, 1) == 1) begin
            for (int j = 0; j < 3 && written < 20; j++) begin
               writeWord(8'($urandom));
               written++;
            end
         end
         stepCycle($urandom_range(0, 1) == 1);
         obs = {rd_valid, rd_data, rempty, raempty, rd_count, rptr, raddr};
         exp = {mValid, mData, mEmpty, mAempty, 4'(mCount), gray(rcount), 3'(rcount)};
         total++;
         if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL wrap_cycle%0d: got %h expected %h", c, obs, exp);
         end
         total++;
         if (rd_count > 4'd8) begin
            bad++;
            $display("[TB] FAIL wrap_level%0d: got rd_count=%0d expected <=8", c, rd_count);
         end
      end
      total++;
      if (received.size() != 20) begin
         bad++;
         $display("[TB] FAIL wrap_count: got %0d words expected 20", received.size());
      end
      for (int i = 0; i < 20 && i < received.size(); i++) begin
         total++;
         if (received[i] !== words[i]) begin
            bad++;
            $display("[TB] FAIL wrap_order%0d: got %h expected %h", i, received[i], words[i]);
         end
      end
   endtask

   task automatic test_pointer_jump();
      doReset();
      for (int i = 0; i < 5; i++) writeWord(8'($urandom));
      stepCycle(1'b0);
      total++;
      if ({rd_count, raempty, rempty} !== {4'd5, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL jump_flags: got %b expected %b", {rd_count, raempty, rempty}, {4'd5, 1'b0, 1'b0});
      end
      for (int c = 0; c < 20 && received.size() < 5; c++) stepCycle(1'b1);
      total++;
      if (received.size() != 5) begin
         bad++;
         $display("[TB] FAIL jump_count: got %0d words expected 5", received.size());
      end
      for (int i = 0; i < 5 && i < received.size(); i++) begin
         total++;
         if (received[i] !== words[i]) begin
            bad++;
            $display("[TB] FAIL jump_order%0d: got %h expected %h", i, received[i], words[i]);
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic [18:0] obs, exp;
      doReset();
      for (int i = 0; i < 3; i++) writeWord(8'($urandom_range(1, 255)));
      stepCycle(1'b0);
      stepCycle(1'b0);
      total++;
      if (rd_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_valid: got rd_valid=%b expected 1", rd_valid);
      end
      rrst = 1'b1;
      #1;
      obs = {rd_valid, rempty, raempty, rptr, rd_count, rd_data};
      exp = {1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 8'h00};
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL mid_reset: got %h expected %h", obs, exp);
      end
      doReset();
   endtask

   initial begin
      $display("[TB] starting fifo_rd_ctrl bench");
      test_reset();
      test_single_word();
      test_streaming();
      test_backpressure();
      test_wrap();
      test_pointer_jump();
      test_midstream_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
